// File: rtl/ram_fifo_ctrl_8x16_pkg.sv
// Shared constants and FSM state type for the RAM-backed FIFO controller.
// Optional almost-full output is enabled by defining RAM_FIFO_ALMOST_EN.
package ram_fifo_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = ADDR_W + 1;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_PEND = 1'b1
   } state_e;

endpackage

// File: rtl/ram_fifo_ctrl_8x16_if.sv
// Valid/ready write stream and output stream of the RAM FIFO controller.
// The FIFO controller takes the slave modport; the producer/consumer side takes master.
interface ram_fifo_ctrl_8x16_if;
   import ram_fifo_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

endinterface

// File: rtl/ram_fifo_ctrl_8x16.sv
// FIFO controller driving an external 8x16 dual-port RAM with registered reads.
// Define RAM_FIFO_ALMOST_EN to add parameter AF_LEVEL and output almost_full.
module ram_fifo_ctrl_8x16
   import ram_fifo_pkg::*;
`ifdef RAM_FIFO_ALMOST_EN
#(
   parameter int AF_LEVEL = 6
)
`endif
(
   input  logic                 clk,
   input  logic                 rst_n,
   ram_fifo_ctrl_8x16_if.slave  s,
   output logic [CNT_W-1:0]     level,
   output logic                 full,
   output logic                 empty,
`ifdef RAM_FIFO_ALMOST_EN
   output logic                 almost_full,
`endif
   output logic                 ram_we,
   output logic                 ram_en,
   output logic [ADDR_W-1:0]    ram_addr_w,
   output logic [ADDR_W-1:0]    ram_addr_r,
   output logic [DATA_W-1:0]    ram_data_w,
   input  logic [DATA_W-1:0]    ram_data_r
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   cnt_t              count_q, count_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;

   logic              rd_pend;
   logic              rd_issue;
   logic              wr_fire;
   logic              in_ready_w;

   assign rd_pend  = (state_q == RD_PEND);
   // A read may only issue when the output slot will be free by the time the data returns.
   assign rd_issue = (state_q == IDLE) && (count_q != '0) && (!out_valid_q || s.out_ready);
   // Reads win the single RAM port slot; rst_n gating keeps in_ready low while held in reset.
   assign in_ready_w = rst_n && (count_q != cnt_t'(DEPTH)) && !rd_issue;
   assign wr_fire  = s.in_valid && in_ready_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (rd_issue) begin
               state_d  = RD_PEND;
               rd_ptr_d = rd_ptr_q + 1'b1;
               count_d  = count_q - cnt_t'(1);
            end else if (wr_fire) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + cnt_t'(1);
            end
            if (out_valid_q && s.out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         RD_PEND: begin
            state_d     = IDLE;
            out_data_d  = ram_data_r;
            out_valid_d = 1'b1;
            if (wr_fire) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + cnt_t'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign s.in_ready  = in_ready_w;
   assign s.out_valid = out_valid_q;
   assign s.out_data  = out_data_q;

   assign level = count_q + cnt_t'(rd_pend) + cnt_t'(out_valid_q);
   assign full  = (count_q == cnt_t'(DEPTH));
   assign empty = (level == '0);

`ifdef RAM_FIFO_ALMOST_EN
   assign almost_full = (level >= cnt_t'(AF_LEVEL));
`endif

   assign ram_we     = wr_fire;
   assign ram_en     = rd_issue;
   assign ram_addr_w = wr_ptr_q;
   assign ram_addr_r = rd_ptr_q;
   assign ram_data_w = s.in_data;

endmodule

// File: tb/tb_ram_fifo_ctrl_8x16.sv
// Directed bench for ram_fifo_ctrl_8x16 with a behavioural 8x16 registered-read RAM.
// Define RAM_FIFO_ALMOST_EN to also exercise almost_full.
module tb_ram_fifo_ctrl_8x16;

   logic        clk;
   logic        rst_n;
   logic [3:0]  level;
   logic        full;
   logic        empty;
`ifdef RAM_FIFO_ALMOST_EN
   logic        almost_full;
`endif
   logic        ram_we;
   logic        ram_en;
   logic [2:0]  ram_addr_w;
   logic [2:0]  ram_addr_r;
   logic [15:0] ram_data_w;
   logic [15:0] ram_data_r;

   int n_cmp;
   int n_fail;

   ram_fifo_ctrl_8x16_if bus ();

`ifdef RAM_FIFO_ALMOST_EN
   ram_fifo_ctrl_8x16 #(.AF_LEVEL(6)) dut (
`else
   ram_fifo_ctrl_8x16 dut (
`endif
      .clk         (clk),
      .rst_n       (rst_n),
      .s           (bus),
      .level       (level),
      .full        (full),
      .empty       (empty),
`ifdef RAM_FIFO_ALMOST_EN
      .almost_full (almost_full),
`endif
      .ram_we      (ram_we),
      .ram_en      (ram_en),
      .ram_addr_w  (ram_addr_w),
      .ram_addr_r  (ram_addr_r),
      .ram_data_w  (ram_data_w),
      .ram_data_r  (ram_data_r)
   );

   // Behavioural dual-port RAM: write when we&!en, registered read when en&!we
   logic [15:0] mem [8];
   logic [15:0] ram_rd_q;

   always @(posedge clk) begin
      if (ram_we && !ram_en) mem[ram_addr_w] <= ram_data_w;
      if (ram_en && !ram_we) ram_rd_q <= mem[ram_addr_r];
   end
   assign ram_data_r = ram_rd_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b want=0", bus.in_ready); end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
      n_cmp++;
      if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level got=%0d want=0", level); end
      n_cmp++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got=%b want=1", empty); end
      n_cmp++;
      if ({ram_we, ram_en} !== 2'b00) begin n_fail++; $display("FAIL rst_ram_strobes got=%b want=00", {ram_we, ram_en}); end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got=%b want=1", bus.in_ready); end
      n_cmp++;
      if ({empty, level} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL post_rst_empty_level got=%b/%0d want=1/0", empty, level); end
   endtask

   task automatic test_fill;
      int k;
      bit acc;
      k = 0;
      bus.out_ready = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         bus.in_valid = (k < 11);
         bus.in_data  = 16'(32'hA000 + k);
         #1;
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) k++;
      end
      bus.in_valid = 1'b0;
      #1;
      n_cmp++;
      if (k !== 9) begin n_fail++; $display("FAIL fill_accepted got=%0d want=9", k); end
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got=%b want=0", bus.in_ready); end
      n_cmp++;
      if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b want=1", full); end
      n_cmp++;
      if (level !== 4'd9) begin n_fail++; $display("FAIL fill_level got=%0d want=9", level); end
      n_cmp++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 16'hA000}) begin
         n_fail++; $display("FAIL fill_out_data got=%b/%h want=1/a000", bus.out_valid, bus.out_data);
      end
   endtask

   task automatic test_drain;
      int n;
      int cyc;
      n = 0;
      cyc = 0;
      bus.out_ready = 1'b1;
      while (n < 9 && cyc < 60) begin
         if (bus.out_valid) begin
            n_cmp++;
            if (bus.out_data !== 16'(32'hA000 + n)) begin
               n_fail++; $display("FAIL drain_word%0d got=%h want=%h", n, bus.out_data, 16'(32'hA000 + n));
            end
            n++;
         end
         tick();
         cyc++;
      end
      n_cmp++;
      if (n !== 9) begin n_fail++; $display("FAIL drain_count got=%0d want=9", n); end
      n_cmp++;
      if ({empty, level} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL drain_empty_level got=%b/%0d want=1/0", empty, level); end
   endtask

   task automatic test_back_to_back;
      int p;
      int r;
      int cyc;
      bit acc;
      p = 0;
      r = 0;
      cyc = 0;
      bus.out_ready = 1'b1;
      while ((p < 24 || r < 24) && cyc < 200) begin
         bus.in_valid = (p < 24);
         bus.in_data  = 16'(p);
         #1;
         n_cmp++;
         if ((ram_we && ram_en) !== 1'b0) begin n_fail++; $display("FAIL b2b_we_en_exclusive cyc=%0d got=1 want=0", cyc); end
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid) begin
            n_cmp++;
            if (bus.out_data !== 16'(r)) begin n_fail++; $display("FAIL b2b_word%0d got=%h want=%h", r, bus.out_data, 16'(r)); end
            r++;
         end
         tick();
         if (acc) p++;
         cyc++;
      end
      bus.in_valid = 1'b0;
      #1;
      n_cmp++;
      if ({p, r} !== {32'd24, 32'd24}) begin n_fail++; $display("FAIL b2b_counts got=%0d/%0d want=24/24", p, r); end
      // 9 + 24 = 33 writes and reads since reset: both pointers land on 1
      n_cmp++;
      if ({ram_addr_w, ram_addr_r} !== {3'd1, 3'd1}) begin
         n_fail++; $display("FAIL b2b_ptr_wrap got=%0d/%0d want=1/1", ram_addr_w, ram_addr_r);
      end
      n_cmp++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got=%b want=1", empty); end
   endtask

   task automatic test_reset_mid_read;
      int waited;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h1234;
      #1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      n_cmp++;
      if (level !== 4'd1) begin n_fail++; $display("FAIL rdpend_level got=%0d want=1", level); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
      n_cmp++;
      if (level !== 4'd0) begin n_fail++; $display("FAIL midrst_level got=%0d want=0", level); end
      tick();
      rst_n = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h5A5A;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      waited = 0;
      while (!bus.out_valid && waited < 10) begin
         tick();
         waited++;
      end
      n_cmp++;
      if (waited !== 2) begin n_fail++; $display("FAIL midrst_latency got=%0d want=2", waited); end
      n_cmp++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 16'h5A5A}) begin
         n_fail++; $display("FAIL midrst_first_word got=%b/%h want=1/5a5a", bus.out_valid, bus.out_data);
      end
      tick();
      n_cmp++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got=%b want=1", empty); end
   endtask

`ifdef RAM_FIFO_ALMOST_EN
   task automatic test_almost_full;
      int k;
      bit acc;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_reset got=%b want=0", almost_full); end
      k = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'(32'hC000 + cyc);
         #1;
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) k++;
         n_cmp++;
         if (level !== 4'(k)) begin n_fail++; $display("FAIL af_level got=%0d want=%0d", level, k); end
         n_cmp++;
         if (almost_full !== (k >= 6)) begin n_fail++; $display("FAIL af_flag level=%0d got=%b want=%b", k, almost_full, (k >= 6)); end
      end
      bus.in_valid = 1'b0;
   endtask
`endif

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_reset_mid_read();
`ifdef RAM_FIFO_ALMOST_EN
      test_almost_full();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
